bayer_bin2x2: RTL and testbench
===============================

# bayer_bin2x2

Converts the raw Bayer pixel stream from the TRDB-D5M sensor driver into a half-resolution RGB stream for the ADV7123 display path. Each 2x2 Bayer quad (GRBG) becomes one RGB pixel, using a single internal line buffer. Sits between the sensor driver and the image-transfer path. Non-stallable: the sensor cannot be back-pressured, so there is no ready signal.

## Interface
- MAX_LINE_PIXELS, 1280: maximum raw pixels per line; must be even.
- RAW_W, 12: raw pixel width.
- OUT_W, 10: RGB channel width; must satisfy OUT_W <= RAW_W.
- ul1Clock  in  1  pixel clock; all logic on rising edge.
- ul1Reset_n  in  1  asynchronous, active-low reset.
- raw_valid  in  1  raw pixel present this cycle.
- raw_data  in  RAW_W  raw Bayer pixel.
- raw_sof  in  1  first pixel of frame; qualified by raw_valid.
- raw_eol  in  1  last pixel of line; qualified by raw_valid.
- rgb_valid  out  1  output pixel present (one-cycle pulse).
- rgb_r, rgb_g, rgb_b  out  OUT_W each  output channels.
- rgb_sof  out  1  first output pixel of frame.
- rgb_eol  out  1  last output pixel of line.
- err_odd_line  out  1  sticky: a line ended after an odd number of pixels.
- err_overflow  out  1  sticky: a line exceeded MAX_LINE_PIXELS.

## Operation
- States:
  - WAIT_SOF: reset state.
  - EVEN_ROW: row 0 of the quad; G R G R ...
  - ODD_ROW: row 1 of the quad; B G B G ...
- Transitions:
  - raw_valid & raw_sof: go to EVEN_ROW from any state; column counter := 0. The SOF pixel itself is processed as column 0 of EVEN_ROW.
  - raw_valid & raw_eol: EVEN_ROW -> ODD_ROW, ODD_ROW -> EVEN_ROW; column counter := 0.
- Pixels received in WAIT_SOF are discarded.
- EVEN_ROW:
  - Latch the even-column pixel (G0).
  - On the odd-column pixel (R), write {G0,R} (2*RAW_W bits) to line buffer address col/2.
- ODD_ROW:
  - On the even-column pixel (B): issue a line-buffer read at col/2 and latch B.
  - On the odd-column pixel (G1): compute and emit one RGB pixel.
- Arithmetic:
  - rgb_r = R[RAW_W-1 -: OUT_W]
  - rgb_b = B[RAW_W-1 -: OUT_W]
  - rgb_g = (G0+G1), computed as a RAW_W+1-bit sum, take bits [RAW_W -: OUT_W] (average, then truncate). No rounding.
- Output flags:
  - rgb_sof is set on the first output of a frame: the first ODD_ROW pair after an SOF.
  - rgb_eol is set on the output produced by the odd-row pixel carrying raw_eol.
- Boundary conditions:
  - Column counter reaches MAX_LINE_PIXELS before EOL: later pixels in that line are dropped (no write, no output); err_overflow := 1.
  - EOL on an even-column (unpaired) pixel: err_odd_line := 1. The unpaired pixel produces no write or output; its row still toggles.
  - An odd row longer than the preceding even row reads stale buffer data. This is permitted and undetected.
  - Sticky error flags clear only on reset.
  - raw_sof together with raw_eol on the same pixel: apply SOF first, then EOL. The resulting state is ODD_ROW and err_odd_line is set.
- Input gaps (raw_valid low) are allowed anywhere. The line-buffer read data must stay stable until the paired G1 arrives.

## Timing
- Reset values:
  - rgb_valid, rgb_sof, rgb_eol = 0
  - rgb_r/g/b = 0
  - error flags = 0
  - state = WAIT_SOF
  - counters = 0
- Latency: rgb_* are registered outputs, asserted exactly 1 cycle after the raw_valid cycle of the G1 pixel.
- Line-buffer read has 1-cycle latency. It is issued on the B pixel, so it completes by the earliest G1 (back-to-back input).
- Maximum throughput: one output every 2 input cycles. rgb_valid is never high on consecutive cycles.
- Reset mid-frame: all outputs clear asynchronously. Output resumes only after the next raw_sof plus one even row.

## Structure
- Shared package bayer_pkg holds:
  - the GRBG phase constants;
  - the state enum (WAIT_SOF/EVEN_ROW/ODD_ROW);
  - the function computing output-channel truncation.
- One sub-module: bayer_line_ram, a simple dual-port RAM.
  - MAX_LINE_PIXELS/2 deep, 2*RAW_W wide.
  - Synchronous write and registered read; inferable as block RAM.

## Test plan
- 4x2 frame, row0 = {G=0x800,R=0xFFF,G=0x400,R=0x000}, row1 = {B=0x004,G=0x800,B=0xFFC,G=0x400}, back-to-back valid:
  - two outputs: (R=0x3FF,G=0x200,B=0x001) and (R=0x000,G=0x100,B=0x3FF);
  - first output has rgb_sof=1, second has rgb_eol=1;
  - each output appears 1 cycle after its G1 pixel.
- Same frame with raw_valid toggling every other cycle -> identical output values, each rgb_valid 1 cycle after its G1.
- Pixels before the first raw_sof after reset -> no rgb_valid.
- Line of MAX_LINE_PIXELS+2 pixels -> err_overflow=1; exactly MAX_LINE_PIXELS/2 outputs on the odd row.
- 3-pixel line with EOL -> err_odd_line=1; the row still toggles.
- Reset asserted during ODD_ROW mid-line:
  - outputs go to 0 immediately;
  - no output until a new SOF frame completes its first odd-row pair.

Source files
------------

// File: rtl/bayer_pkg.sv
// bayer_pkg: GRBG phase constants, row-tracking states and channel truncation shared by the binning path.
package bayer_pkg;
  typedef enum logic [1:0] {WAIT_SOF = 2'd0, EVEN_ROW = 2'd1, ODD_ROW = 2'd2} state_t;
  // Phase = {odd row, odd column}
  localparam logic [1:0] PH_G0 = 2'b00;
  localparam logic [1:0] PH_R  = 2'b01;
  localparam logic [1:0] PH_B  = 2'b10;
  localparam logic [1:0] PH_G1 = 2'b11;
  function automatic logic [31:0] truncTop(input logic [31:0] v, input int inW, input int outW);
    return v >> (inW - outW);
  endfunction
endpackage

// File: rtl/bayer_line_ram.sv
// bayer_line_ram: simple dual-port line buffer with synchronous write and registered, held read data.
module bayer_line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/bayer_bin2x2.sv
// bayer_bin2x2: bins each GRBG 2x2 quad of the raw sensor stream into one half-resolution RGB pixel.
module bayer_bin2x2
  import bayer_pkg::*;
#(
  parameter int MAX_LINE_PIXELS = 1280,
  parameter int RAW_W = 12,
  parameter int OUT_W = 10
) (
  input  logic             ul1Clock,
  input  logic             ul1Reset_n,
  input  logic             raw_valid,
  input  logic [RAW_W-1:0] raw_data,
  input  logic             raw_sof,
  input  logic             raw_eol,
  output logic             rgb_valid,
  output logic [OUT_W-1:0] rgb_r,
  output logic [OUT_W-1:0] rgb_g,
  output logic [OUT_W-1:0] rgb_b,
  output logic             rgb_sof,
  output logic             rgb_eol,
  output logic             err_odd_line,
  output logic             err_overflow
);
  localparam int COL_W = $clog2(MAX_LINE_PIXELS + 1);
  localparam int ADDR_W = $clog2(MAX_LINE_PIXELS / 2);
  state_t state, effState;
  logic [COL_W-1:0] col, effCol;
  logic [RAW_W-1:0] g0, bPix;
  logic [2*RAW_W-1:0] ramQ;
  logic [RAW_W:0] gSum;
  logic [ADDR_W-1:0] addr;
  logic [1:0] phase;
  logic sofPending, inRange, act, wrEn, rdEn, emit;
  // SOF restarts the frame on the very pixel that carries it
  always_comb begin
    effState = raw_sof ? EVEN_ROW : state;
    effCol = raw_sof ? '0 : col;
    inRange = effCol < COL_W'(MAX_LINE_PIXELS);
    phase = {effState == ODD_ROW, effCol[0]};
    act = raw_valid && inRange && effState != WAIT_SOF;
    wrEn = act && phase == PH_R;
    rdEn = act && phase == PH_B;
    emit = act && phase == PH_G1;
    addr = ADDR_W'(effCol >> 1);
    gSum = {1'b0, ramQ[2*RAW_W-1:RAW_W]} + {1'b0, raw_data};
  end
  bayer_line_ram #(.DEPTH(MAX_LINE_PIXELS / 2), .WIDTH(2 * RAW_W), .AW(ADDR_W)) lineRam (
    .clk(ul1Clock), .wrEn(wrEn), .wrAddr(addr), .wrData({g0, raw_data}),
    .rdEn(rdEn), .rdAddr(addr), .rdData(ramQ)
  );
  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) begin
      state <= WAIT_SOF;
      col <= '0;
      g0 <= '0;
      bPix <= '0;
      sofPending <= 1'b0;
      rgb_valid <= 1'b0;
      rgb_sof <= 1'b0;
      rgb_eol <= 1'b0;
      rgb_r <= '0;
      rgb_g <= '0;
      rgb_b <= '0;
      err_odd_line <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rgb_valid <= emit;
      rgb_sof <= emit && sofPending;
      rgb_eol <= emit && raw_eol;
      if (emit) begin
        rgb_r <= OUT_W'(truncTop(32'(ramQ[RAW_W-1:0]), RAW_W, OUT_W));
        rgb_g <= OUT_W'(truncTop(32'(gSum), RAW_W + 1, OUT_W));
        rgb_b <= OUT_W'(truncTop(32'(bPix), RAW_W, OUT_W));
      end
      if (act && phase == PH_G0) g0 <= raw_data;
      if (rdEn) bPix <= raw_data;
      if (raw_valid && raw_sof) sofPending <= 1'b1;
      else if (emit) sofPending <= 1'b0;
      if (raw_valid && effState != WAIT_SOF) begin
        if (raw_eol) begin
          state <= effState == EVEN_ROW ? ODD_ROW : EVEN_ROW;
          col <= '0;
          if (inRange && !effCol[0]) err_odd_line <= 1'b1;
        end else begin
          state <= effState;
          col <= inRange ? effCol + 1'b1 : effCol;
        end
        if (!inRange) err_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bayer_bin2x2.sv
// tb_bayer_bin2x2: directed vector table plus hand-written corner sequences for the 2x2 Bayer binner.
module tb_bayer_bin2x2;
  localparam int MAXP = 1280;
  logic clk = 1'b0, rst_n = 1'b0;
  logic raw_valid = 1'b0, raw_sof = 1'b0, raw_eol = 1'b0;
  logic [11:0] raw_data = '0;
  logic rgb_valid, rgb_sof, rgb_eol, err_odd_line, err_overflow;
  logic [9:0] rgb_r, rgb_g, rgb_b;
  int errors = 0, checks = 0, validCnt = 0, b2b = 0;
  logic prevValid = 1'b0;

  bayer_bin2x2 dut (
    .ul1Clock(clk), .ul1Reset_n(rst_n), .raw_valid(raw_valid), .raw_data(raw_data),
    .raw_sof(raw_sof), .raw_eol(raw_eol), .rgb_valid(rgb_valid), .rgb_r(rgb_r),
    .rgb_g(rgb_g), .rgb_b(rgb_b), .rgb_sof(rgb_sof), .rgb_eol(rgb_eol),
    .err_odd_line(err_odd_line), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rgb_valid) validCnt++;
    if (rgb_valid && prevValid) b2b++;
    prevValid = rgb_valid;
  end

  typedef struct {
    logic [11:0] d;
    logic s, e, ev, es, ee;
    logic [9:0] r, g, b;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] d, input logic s, input logic e);
    raw_valid = 1'b1; raw_data = d; raw_sof = s; raw_eol = e;
    @(negedge clk);
    raw_valid = 1'b0; raw_sof = 1'b0; raw_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic row(input int n, input logic s);
    for (int i = 0; i < n; i++) drive(12'(i * 7), s && i == 0, i == n - 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic runTable(input logic gaps);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].e);
      #1;
      if (tbl[i].ev)
        check($sformatf("tbl%0d_g%0d", i, gaps), {rgb_valid, rgb_sof, rgb_eol, rgb_r, rgb_g, rgb_b},
              {tbl[i].ev, tbl[i].es, tbl[i].ee, tbl[i].r, tbl[i].g, tbl[i].b});
      else
        check($sformatf("tbl%0d_g%0d", i, gaps), {rgb_valid, rgb_sof, rgb_eol}, 3'b000);
      if (gaps) begin
        @(negedge clk);
        #1;
        check($sformatf("gap%0d", i), rgb_valid, 1'b0);
      end
    end
  endtask

  initial begin
    int base;
    tbl[0] = '{12'h800, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{12'hFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{12'h400, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{12'h000, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{12'h004, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{12'h800, 0, 0, 1, 1, 0, 10'h3FF, 10'h200, 10'h001};
    tbl[6] = '{12'hFFC, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{12'h400, 0, 1, 1, 0, 1, 10'h000, 10'h100, 10'h3FF};
    #1;
    check("reset_outs", {rgb_valid, rgb_sof, rgb_eol, rgb_r, rgb_g, rgb_b, err_odd_line, err_overflow}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    runTable(1'b0);
    runTable(1'b1);
    check("table_errs", {err_odd_line, err_overflow}, 2'b00);

    doReset();
    base = validCnt;
    row(4, 1'b0);
    row(4, 1'b0);
    idle(2);
    check("pre_sof_outputs", validCnt - base, 0);

    doReset();
    row(MAXP + 2, 1'b1);
    idle(1);
    check("ovf_flag", err_overflow, 1'b1);
    base = validCnt;
    row(MAXP + 2, 1'b0);
    idle(2);
    check("ovf_outputs", validCnt - base, MAXP / 2);
    check("ovf_no_odd", err_odd_line, 1'b0);

    doReset();
    row(3, 1'b1);
    idle(1);
    check("odd_line_flag", err_odd_line, 1'b1);
    base = validCnt;
    row(4, 1'b0);
    idle(2);
    check("odd_line_toggle", validCnt - base, 2);
    check("odd_line_no_ovf", err_overflow, 1'b0);

    doReset();
    drive(12'h123, 1'b1, 1'b1);
    idle(1);
    check("sof_eol_odd", err_odd_line, 1'b1);
    base = validCnt;
    drive(12'h004, 1'b0, 1'b0);
    drive(12'h008, 1'b0, 1'b1);
    #1;
    check("sof_eol_out", {rgb_valid, rgb_sof, rgb_eol, rgb_b}, {3'b111, 10'h001});
    idle(1);
    check("sof_eol_cnt", validCnt - base, 1);

    doReset();
    row(4, 1'b1);
    drive(12'h004, 1'b0, 1'b0);
    drive(12'h800, 1'b0, 1'b0);
    #1;
    check("mid_pre_valid", rgb_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_async_clr", {rgb_valid, rgb_sof, rgb_eol, rgb_r, rgb_g, rgb_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    base = validCnt;
    drive(12'hFFC, 1'b0, 1'b0);
    drive(12'h400, 1'b0, 1'b1);
    row(4, 1'b0);
    idle(1);
    check("mid_no_out", validCnt - base, 0);
    for (int i = 0; i < 4; i++) drive(tbl[i].d, tbl[i].s, tbl[i].e);
    idle(1);
    check("mid_even_quiet", validCnt - base, 0);
    drive(12'h004, 1'b0, 1'b0);
    drive(12'h800, 1'b0, 1'b0);
    #1;
    check("mid_resume", {rgb_valid, rgb_sof, rgb_r, rgb_g, rgb_b}, {2'b11, 10'h3FF, 10'h200, 10'h001});
    idle(2);
    check("no_b2b_valid", b2b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
